// File: rtl/xm_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, FSM states,
// and fault cause codes.
package xm_pkg;

  localparam int unsigned WORD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_e;

  // Values reported on fault_cause_o while fault_o is high.
  localparam logic CAUSE_MISALIGN = 1'b0;
  localparam logic CAUSE_TIMEOUT  = 1'b1;

endpackage

// File: rtl/xm_inst_fetch.sv
// Instruction fetch unit: owns the PC and instruction register, issues one
// memory read per fetch request and reports misaligned-PC and memory-timeout faults.
module xm_inst_fetch #(
  parameter int unsigned      WORD      = xm_pkg::WORD,
  parameter logic [WORD-1:0]  RESET_VEC = '0,
  parameter int unsigned      TIMEOUT   = 15
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            fetch_i,
  input  logic            pc_wr_i,
  input  logic [WORD-1:0] pc_i,
  input  logic            mem_rdy_i,
  input  logic [WORD-1:0] mem_data_i,
  output logic            mem_rd_o,
  output logic [WORD-1:0] mem_adr_o,
  output logic [WORD-1:0] inst_o,
  output logic [WORD-1:0] pc_o,
  output logic            inst_valid_o,
  output logic            busy_o,
  output logic            fault_o,
  output logic            fault_cause_o
);

  import xm_pkg::*;

  // Wait counter only has to reach TIMEOUT-1 before the abort fires.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fetch_state_e    r_state, w_state_d;
  logic [WORD-1:0] r_pc, w_pc_d;
  logic [WORD-1:0] r_inst, w_inst_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;
  logic            r_valid, w_valid_d;
  logic            r_fault, w_fault_d;
  logic            r_cause, w_cause_d;

  logic [WORD-1:0] w_eff_adr;
  logic            w_timeout_hit;

  // A PC write in the same cycle as a fetch redirects that fetch.
  assign w_eff_adr     = pc_wr_i ? pc_i : r_pc;
  assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= IDLE;
      r_pc    <= RESET_VEC;
      r_inst  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_cause <= CAUSE_MISALIGN;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_inst  <= w_inst_d;
      r_cnt   <= w_cnt_d;
      r_valid <= w_valid_d;
      r_fault <= w_fault_d;
      r_cause <= w_cause_d;
    end
  end

  // Next-state logic: request handling in IDLE, completion/timeout in FETCH.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_inst_d  = r_inst;
    w_cnt_d   = r_cnt;
    w_valid_d = 1'b0;
    w_fault_d = 1'b0;
    w_cause_d = r_cause;
    case (r_state)
      IDLE: begin
        if (pc_wr_i) begin
          w_pc_d = pc_i;
        end
        if (fetch_i) begin
          if (w_eff_adr[0]) begin
            w_fault_d = 1'b1;
            w_cause_d = CAUSE_MISALIGN;
          end else begin
            w_state_d = FETCH;
            w_cnt_d   = '0;
          end
        end
      end
      FETCH: begin
        if (mem_rdy_i) begin
          w_inst_d  = mem_data_i;
          w_pc_d    = r_pc + WORD'(2);
          w_state_d = IDLE;
          w_valid_d = 1'b1;
        end else if (w_timeout_hit) begin
          w_state_d = IDLE;
          w_fault_d = 1'b1;
          w_cause_d = CAUSE_TIMEOUT;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  assign mem_rd_o      = (r_state == FETCH);
  assign busy_o        = (r_state == FETCH);
  assign mem_adr_o     = r_pc;
  assign pc_o          = r_pc;
  assign inst_o        = r_inst;
  assign inst_valid_o  = r_valid;
  assign fault_o       = r_fault;
  assign fault_cause_o = r_cause;

endmodule
